// File: rtl/procb_thread_sched_pkg.sv
// procb_thread_sched_pkg: FSM encodings and width helper shared by the procb thread scheduler.
package procb_thread_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_BUSY  = 2'd2,
        ST_WB    = 2'd3
    } state_e;

    function automatic int msb(input int v);
        int m;
        m = 0;
        for (int i = 0; i < 32; i++)
            if (((v >> i) & 1) != 0) m = i;
        return m;
    endfunction

endpackage

// File: rtl/procb_thread_sched_if.sv
// procb_thread_sched_if: grant, block-done and saved-state signals between the scheduler and procb.
interface procb_thread_sched_if
    import procb_thread_sched_pkg::*;
#(
    parameter int N_THREADS     = 6,
    parameter int N_THREADS_MSB = msb(N_THREADS - 1)
) ();

    logic [N_THREADS-1:0]   thread_ready;
    logic                   grant_valid;
    logic [N_THREADS_MSB:0] grant_thread_num;
    logic                   grant_restore;
    logic                   grant_ack;
    logic                   blk_done;
    logic                   blk_done_save;
    logic [N_THREADS_MSB:0] ss_rd_thread_num;
    logic                   ss_wr_en;
    logic [N_THREADS_MSB:0] ss_wr_thread_num;
    logic [N_THREADS-1:0]   saved_valid;
    logic                   busy;

    modport master (
        input  thread_ready, grant_ack, blk_done, blk_done_save,
        output grant_valid, grant_thread_num, grant_restore, ss_rd_thread_num,
               ss_wr_en, ss_wr_thread_num, saved_valid, busy
    );

    modport slave (
        output thread_ready, grant_ack, blk_done, blk_done_save,
        input  grant_valid, grant_thread_num, grant_restore, ss_rd_thread_num,
               ss_wr_en, ss_wr_thread_num, saved_valid, busy
    );

endinterface

// File: rtl/procb_rr_select.sv
// procb_rr_select: rotate-priority encoder picking the first requester after last, wrapping modulo N_THREADS.
module procb_rr_select #(
    parameter int N_THREADS     = 6,
    parameter int N_THREADS_MSB = 2
) (
    input  logic [N_THREADS-1:0]   req,
    input  logic [N_THREADS_MSB:0] last,
    output logic [N_THREADS_MSB:0] winner,
    output logic                   any
);

    localparam int W = N_THREADS_MSB + 1;

    logic [W:0] idx;

    // Walk from farthest to nearest so the nearest requester after last wins.
    always_comb begin
        winner = '0;
        idx    = '0;
        for (int i = N_THREADS; i >= 1; i--) begin
            idx = {1'b0, last} + (W+1)'(i);
            if (idx >= (W+1)'(N_THREADS)) idx = idx - (W+1)'(N_THREADS);
            if (req[idx[W-1:0]]) winner = idx[W-1:0];
        end
    end

    assign any = |req;

endmodule

// File: rtl/procb_thread_sched.sv
// procb_thread_sched: round-robin procb thread scheduler with saved-state addressing and valid tracking.
module procb_thread_sched
    import procb_thread_sched_pkg::*;
#(
    parameter int N_THREADS     = 6,
    parameter int N_THREADS_MSB = msb(N_THREADS - 1)
) (
    input logic                  CLK,
    input logic                  RST_N,
    procb_thread_sched_if.master bus
);

    localparam int W = N_THREADS_MSB + 1;
    localparam logic [W-1:0] LAST_RST = W'(N_THREADS - 1);

    state_e               state_q, state_d;
    logic [W-1:0]         last_q, last_d, thr_q, thr_d, wr_thr_q, wr_thr_d, win;
    logic                 restore_q, restore_d, save_q, save_d;
    logic                 valid_q, valid_d, wr_en_q, wr_en_d, busy_q, busy_d;
    logic [N_THREADS-1:0] saved_q, saved_d;
    logic                 any, pick;

    procb_rr_select #(
        .N_THREADS     (N_THREADS),
        .N_THREADS_MSB (N_THREADS_MSB)
    ) u_sel (
        .req    (bus.thread_ready),
        .last   (last_q),
        .winner (win),
        .any    (any)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  state_d = any           ? ST_GRANT : ST_IDLE;
            ST_GRANT: state_d = bus.grant_ack ? ST_BUSY  : ST_GRANT;
            ST_BUSY:  state_d = bus.blk_done  ? ST_WB    : ST_BUSY;
            ST_WB:    state_d = ST_IDLE;
        endcase
    end

    // Outputs are computed from the next state so every port comes straight off a flop.
    always_comb begin
        pick      = (state_q == ST_IDLE) && any;
        last_d    = pick ? win : last_q;
        thr_d     = pick ? win : thr_q;
        restore_d = pick ? saved_q[win] : restore_q;
        save_d    = (state_q == ST_BUSY && bus.blk_done) ? bus.blk_done_save : save_q;
        saved_d   = saved_q;
        if (state_q == ST_WB) saved_d[thr_q] = save_q;
        valid_d   = state_d == ST_GRANT;
        busy_d    = state_d != ST_IDLE;
        wr_en_d   = (state_d == ST_WB) && save_d;
        wr_thr_d  = (state_d == ST_WB) ? thr_q : wr_thr_q;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            last_q    <= LAST_RST;
            thr_q     <= '0;
            restore_q <= 1'b0;
            save_q    <= 1'b0;
            saved_q   <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_thr_q  <= '0;
        end else begin
            last_q    <= last_d;
            thr_q     <= thr_d;
            restore_q <= restore_d;
            save_q    <= save_d;
            saved_q   <= saved_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            wr_en_q   <= wr_en_d;
            wr_thr_q  <= wr_thr_d;
        end
    end

    assign bus.grant_valid      = valid_q;
    assign bus.grant_thread_num = thr_q;
    assign bus.grant_restore    = restore_q;
    assign bus.ss_rd_thread_num = thr_q;
    assign bus.ss_wr_en         = wr_en_q;
    assign bus.ss_wr_thread_num = wr_thr_q;
    assign bus.saved_valid      = saved_q;
    assign bus.busy             = busy_q;

endmodule

// File: tb/tb_procb_thread_sched.sv
// tb_procb_thread_sched: table-driven directed bench for the procb thread scheduler.
module tb_procb_thread_sched;

    logic CLK;
    logic RST_N;

    procb_thread_sched_if #(.N_THREADS(6)) bus ();

    procb_thread_sched #(.N_THREADS(6)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus.master)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic       rst_n;
        logic [5:0] ready;
        logic       ack, done, save;
        logic       e_valid;
        int         e_thr;
        logic       e_rest, e_wr, e_busy;
        logic [5:0] e_saved;
    } vec_t;

    vec_t vq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic add(input logic r, input logic [5:0] rdy, input logic a, d, s,
                       input logic ev, input int et, input logic er, ew, eb, input logic [5:0] es);
        vec_t v;
        v = '{r, rdy, a, d, s, ev, et, er, ew, eb, es};
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input int row, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s row %0d: got %0d expected %0d", name, row, act, exp);
        end
    endtask

    int first_v, gap, wr_cnt, consec;
    logic prev_wr;

    initial begin
        RST_N = 1'b0;
        bus.thread_ready = '0;
        bus.grant_ack = 1'b0;
        bus.blk_done = 1'b0;
        bus.blk_done_save = 1'b0;

        // reset
        add(0, 6'h00, 0, 0, 0, 0, 0, 0, 0, 0, 6'h00);
        add(0, 6'h00, 0, 0, 0, 0, 0, 0, 0, 0, 6'h00);
        // single requester, dropped ready, stray inputs, done with ack
        add(1, 6'h04, 0, 0, 0, 1, 2, 0, 0, 1, 6'h00);
        add(1, 6'h00, 0, 0, 0, 1, 2, 0, 0, 1, 6'h00);
        add(1, 6'h00, 0, 1, 1, 1, 2, 0, 0, 1, 6'h00);
        add(1, 6'h00, 1, 1, 1, 0, 2, 0, 0, 1, 6'h00);
        add(1, 6'h00, 1, 0, 0, 0, 2, 0, 0, 1, 6'h00);
        add(1, 6'h00, 0, 1, 0, 0, 2, 0, 0, 1, 6'h00);
        add(1, 6'h00, 0, 0, 0, 0, 2, 0, 0, 0, 6'h00);
        add(1, 6'h00, 1, 1, 1, 0, 2, 0, 0, 0, 6'h00);
        // reset, then all threads ready: order 0..5,0
        add(0, 6'h3F, 1, 1, 1, 0, 0, 0, 0, 0, 6'h00);
        for (int k = 0; k < 7; k++) begin
            add(1, 6'h3F, 0, 0, 0, 1, k % 6, 0, 0, 1, 6'h00);
            add(1, 6'h3F, 1, 0, 0, 0, k % 6, 0, 0, 1, 6'h00);
            add(1, 6'h3F, 0, 1, 0, 0, k % 6, 0, 0, 1, 6'h00);
            add(1, 6'h3F, 0, 0, 0, 0, k % 6, 0, 0, 0, 6'h00);
        end
        // thread 3 saved then restored then completed
        add(1, 6'h08, 0, 0, 0, 1, 3, 0, 0, 1, 6'h00);
        add(1, 6'h00, 1, 0, 0, 0, 3, 0, 0, 1, 6'h00);
        add(1, 6'h00, 0, 1, 1, 0, 3, 0, 1, 1, 6'h00);
        add(1, 6'h00, 0, 0, 0, 0, 3, 0, 0, 0, 6'h08);
        add(1, 6'h08, 0, 0, 0, 1, 3, 1, 0, 1, 6'h08);
        add(1, 6'h00, 1, 0, 0, 0, 3, 1, 0, 1, 6'h08);
        add(1, 6'h00, 0, 1, 0, 0, 3, 1, 0, 1, 6'h08);
        add(1, 6'h00, 0, 0, 0, 0, 3, 1, 0, 0, 6'h00);
        // build saved_valid=001010, then reset during BUSY of thread 4
        add(1, 6'h02, 0, 0, 0, 1, 1, 0, 0, 1, 6'h00);
        add(1, 6'h00, 1, 0, 0, 0, 1, 0, 0, 1, 6'h00);
        add(1, 6'h00, 0, 1, 1, 0, 1, 0, 1, 1, 6'h00);
        add(1, 6'h00, 0, 0, 0, 0, 1, 0, 0, 0, 6'h02);
        add(1, 6'h08, 0, 0, 0, 1, 3, 0, 0, 1, 6'h02);
        add(1, 6'h00, 1, 0, 0, 0, 3, 0, 0, 1, 6'h02);
        add(1, 6'h00, 0, 1, 1, 0, 3, 0, 1, 1, 6'h02);
        add(1, 6'h00, 0, 0, 0, 0, 3, 0, 0, 0, 6'h0A);
        add(1, 6'h10, 0, 0, 0, 1, 4, 0, 0, 1, 6'h0A);
        add(1, 6'h00, 1, 0, 0, 0, 4, 0, 0, 1, 6'h0A);
        add(0, 6'h00, 0, 1, 1, 0, 0, 0, 0, 0, 6'h00);
        add(1, 6'h3F, 0, 0, 0, 1, 0, 0, 0, 1, 6'h00);
        add(1, 6'h00, 1, 0, 0, 0, 0, 0, 0, 1, 6'h00);
        add(1, 6'h00, 0, 1, 0, 0, 0, 0, 0, 1, 6'h00);
        add(1, 6'h00, 0, 0, 0, 0, 0, 0, 0, 0, 6'h00);

        for (int r = 0; r < vq.size(); r++) begin
            RST_N             = vq[r].rst_n;
            bus.thread_ready  = vq[r].ready;
            bus.grant_ack     = vq[r].ack;
            bus.blk_done      = vq[r].done;
            bus.blk_done_save = vq[r].save;
            @(posedge CLK);
            #1;
            chk("grant_valid", r, int'(bus.grant_valid), int'(vq[r].e_valid));
            chk("grant_thread_num", r, int'(bus.grant_thread_num), vq[r].e_thr);
            chk("ss_rd_thread_num", r, int'(bus.ss_rd_thread_num), vq[r].e_thr);
            chk("ss_wr_en", r, int'(bus.ss_wr_en), int'(vq[r].e_wr));
            chk("busy", r, int'(bus.busy), int'(vq[r].e_busy));
            chk("saved_valid", r, int'(bus.saved_valid), int'(vq[r].e_saved));
            if (vq[r].e_valid) chk("grant_restore", r, int'(bus.grant_restore), int'(vq[r].e_rest));
            if (vq[r].e_wr) chk("ss_wr_thread_num", r, int'(bus.ss_wr_thread_num), vq[r].e_thr);
        end

        // back-to-back grants of thread 1 with ack/done held high: 4-cycle period, one-cycle writes
        RST_N = 1'b1;
        bus.thread_ready = 6'h02;
        bus.grant_ack = 1'b1;
        bus.blk_done = 1'b1;
        bus.blk_done_save = 1'b1;
        first_v = -1;
        gap = -1;
        wr_cnt = 0;
        consec = 0;
        prev_wr = 1'b0;
        for (int c = 0; c < 16; c++) begin
            @(posedge CLK);
            #1;
            if (bus.grant_valid) begin
                if (first_v < 0) first_v = c;
                else if (gap < 0) gap = c - first_v;
            end
            if (bus.ss_wr_en) begin
                wr_cnt++;
                if (prev_wr) consec++;
            end
            prev_wr = bus.ss_wr_en;
        end
        chk("turnaround", 100, gap, 4);
        chk("wr_pulses", 100, wr_cnt, 4);
        chk("wr_consecutive", 100, consec, 0);
        chk("saved_after_loop", 100, int'(bus.saved_valid), 6'h02);

        bus.thread_ready = '0;
        bus.grant_ack = 1'b0;
        bus.blk_done = 1'b0;
        bus.blk_done_save = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
